// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding, default
// frame width and the effective-frame-length helper.
package spi_master_pkg;

    localparam int unsigned DATA_W_DEF = 48;
    localparam int unsigned NBITS_W    = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        TAIL = 3'd4,
        GAP  = 3'd5
    } state_t;

    // A zero or oversized length request means a full-width frame.
    function automatic int unsigned frame_len(input logic [NBITS_W-1:0] nbits,
                                              input int unsigned        data_w);
        int unsigned n;
        n = 32'(nbits);
        if (n == 32'd0 || n > data_w) begin
            frame_len = data_w;
        end else begin
            frame_len = n;
        end
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer: tick marks the last clk cycle of every CLK_DIV-cycle
// phase; restart holds the count at the start of a phase.
module spi_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;

    // Down-counter that reloads itself when it expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (restart || cnt_r == 8'd0) begin
            cnt_r <= RELOAD;
        end else begin
            cnt_r <= cnt_r - 8'd1;
        end
    end

    assign tick = (cnt_r == 8'd0) && !restart;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one variable-length full-duplex frame per request, MSB
// first, with optional chip-select hold between frames.
import spi_master_pkg::*;

module spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NBITS_W-1:0] req_nbits,
    input  logic [DATA_W-1:0]  req_data,
    input  logic               req_hold_cs,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               cs_n
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t              state_r;
    state_t              state_s;
    logic                ready_r;
    logic                tick_s;
    logic                restart_s;
    logic                accept_s;
    logic                rise_s;
    logic                fall_s;
    logic                finish_s;
    logic [CNT_W-1:0]    n_s;
    logic [DATA_W-1:0]   tx_align_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   tx_r;
    logic [DATA_W-1:0]   rx_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                sclk_r;
    logic                mosi_r;
    logic                cs_n_r;
    logic                rsp_valid_r;
    logic                hold_r;

    assign restart_s  = (state_r == IDLE);
    assign n_s        = CNT_W'(frame_len(req_nbits, DATA_W));
    // Left-align the frame so the next bit to send is always the top bit.
    assign tx_align_s = req_data << (DATA_W - 32'(n_s));

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // State register; ready is registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) state_s = LEAD;
                else           state_s = IDLE;
            end
            LEAD, LOW: begin
                if (tick_s) state_s = HIGH;
                else        state_s = state_r;
            end
            HIGH: begin
                if (!tick_s)                       state_s = HIGH;
                else if (bit_cnt_r != CNT_W'(0))   state_s = LOW;
                else                               state_s = TAIL;
            end
            TAIL: begin
                if (!tick_s)     state_s = TAIL;
                else if (hold_r) state_s = IDLE;
                else             state_s = GAP;
            end
            GAP: begin
                if (tick_s) state_s = IDLE;
                else        state_s = GAP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        accept_s = 1'b0;
        rise_s   = 1'b0;
        fall_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE:      accept_s = req_valid;
            LEAD, LOW: rise_s   = tick_s;
            HIGH:      fall_s   = tick_s;
            TAIL:      finish_s = tick_s;
            default:   accept_s = 1'b0;
        endcase
    end

    // Shift registers, bit counter and registered SPI/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r   <= CNT_W'(0);
            tx_r        <= {DATA_W{1'b0}};
            rx_r        <= {DATA_W{1'b0}};
            rsp_data_r  <= {DATA_W{1'b0}};
            sclk_r      <= 1'b0;
            mosi_r      <= 1'b0;
            cs_n_r      <= 1'b1;
            rsp_valid_r <= 1'b0;
            hold_r      <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            if (accept_s) begin
                tx_r      <= tx_align_s;
                rx_r      <= {DATA_W{1'b0}};
                bit_cnt_r <= n_s;
                hold_r    <= req_hold_cs;
                cs_n_r    <= 1'b0;
                mosi_r    <= tx_align_s[DATA_W-1];
            end
            if (rise_s) begin
                sclk_r    <= 1'b1;
                rx_r      <= {rx_r[DATA_W-2:0], miso};
                bit_cnt_r <= bit_cnt_r - CNT_W'(1);
            end
            if (fall_s) begin
                sclk_r <= 1'b0;
                if (bit_cnt_r != CNT_W'(0)) begin
                    tx_r   <= {tx_r[DATA_W-2:0], 1'b0};
                    mosi_r <= tx_r[DATA_W-2];
                end
            end
            if (finish_s) begin
                rsp_valid_r <= 1'b1;
                rsp_data_r  <= rx_r;
                if (!hold_r) cs_n_r <= 1'b1;
            end
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign sclk      = sclk_r;
    assign mosi      = mosi_r;
    assign cs_n      = cs_n_r;

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master: frames are checked against a
// bit-level reference model built from the recorded serial traffic.
`timescale 1ns/1ps
module tb_spi_master;

    localparam int unsigned DW  = 48;
    localparam int unsigned DIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_ready, req_hold_cs = 1'b0;
    logic [5:0]    req_nbits = 6'd0;
    logic [DW-1:0] req_data = '0, rsp_data;
    logic          rsp_valid, sclk, mosi, miso, cs_n;

    logic          req_valid2 = 1'b0, req_ready2, rsp_valid2, sclk2, mosi2, cs_n2;
    logic [DW-1:0] rsp_data2;

    int   n_checks = 0, n_errors = 0;
    int   cyc = 0;
    int   miso_mode = 0;
    logic miso_rnd = 1'b0;

    // Monitor state
    logic sclk_p = 1'b0, mosi_p = 1'b0, ready_p = 1'b1, rst_p = 1'b1, cs_p = 1'b1, sclk2_p = 1'b0;
    int   rises = 0, total_rises = 0, rises2 = 0, rsp_cnt = 0, acc_cnt = 0;
    int   cs_high_cnt = 0, mosi_bad = 0, stab = 0, gap_run = 0, min_gap = 1000000;
    bit   gap_open = 1'b0;
    logic mosi_q[$];
    logic miso_q[$];

    assign miso = (miso_mode == 0) ? mosi : ((miso_mode == 2) ? 1'b1 : miso_rnd);

    spi_master #(.CLK_DIV(DIV), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_nbits(req_nbits), .req_data(req_data), .req_hold_cs(req_hold_cs),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sclk(sclk), .mosi(mosi),
        .miso(miso), .cs_n(cs_n)
    );

    spi_master #(.CLK_DIV(2), .DATA_W(DW)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_nbits(6'd1), .req_data(48'd1), .req_hold_cs(1'b0),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .sclk(sclk2), .mosi(mosi2),
        .miso(1'b0), .cs_n(cs_n2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe serial traffic away from the active edge.
    always @(negedge clk) begin
        stab = (mosi != mosi_p) ? 0 : stab + 1;
        if (mosi != mosi_p && !(sclk_p && !sclk) && !(ready_p && !req_ready) && !rst && !rst_p)
            mosi_bad++;
        if (sclk && !sclk_p) begin
            rises++;
            total_rises++;
            mosi_q.push_back(mosi);
            miso_q.push_back(miso);
            if (stab < DIV) mosi_bad++;
        end
        if (sclk_p && !sclk && miso_mode == 1) miso_rnd = 1'($urandom_range(0, 1));
        if (rsp_valid) rsp_cnt++;
        if (req_valid && req_ready && !rst) acc_cnt++;
        if (cs_n) begin
            cs_high_cnt++;
            if (!cs_p) begin gap_open = 1'b1; gap_run = 0; end
            gap_run++;
        end else if (cs_p && gap_open) begin
            if (gap_run < min_gap) min_gap = gap_run;
            gap_open = 1'b0;
        end
        if (sclk2 && !sclk2_p) rises2++;
        sclk_p = sclk; mosi_p = mosi; ready_p = req_ready; rst_p = rst; cs_p = cs_n; sclk2_p = sclk2;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and check it against the reference model.
    task automatic run_frame(input int nb, input logic [DW-1:0] d, input logic hold, input int mode);
        int          n, t0;
        bit          seen;
        logic [63:0] mask, got_tx, exp_rx;
        n    = (nb == 0 || nb > DW) ? DW : nb;
        mask = (64'd1 << n) - 64'd1;
        @(posedge clk); #1;
        miso_mode = mode; mosi_q.delete(); miso_q.delete(); rises = 0;
        req_valid = 1'b1; req_nbits = nb[5:0]; req_data = d; req_hold_cs = hold;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin @(negedge clk); seen = req_ready; end
        chk_eq("accept", 64'(seen), 64'd1);
        t0 = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0; req_data = {$urandom, $urandom};
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin @(negedge clk); seen = rsp_valid; end
        chk_eq("rsp_seen", 64'(seen), 64'd1);
        chk_eq("duration", 64'(cyc - t0), 64'(1 + DIV * (2 * n + 1)));
        chk_eq("sclk_rises", 64'(rises), 64'(n));
        got_tx = 64'd0;
        foreach (mosi_q[i]) got_tx = (got_tx << 1) | 64'(mosi_q[i]);
        chk_eq("mosi_bits", got_tx, 64'(d) & mask);
        if (mode == 0) exp_rx = 64'(d) & mask;
        else if (mode == 2) exp_rx = mask;
        else begin
            exp_rx = 64'd0;
            foreach (miso_q[i]) exp_rx = (exp_rx << 1) | 64'(miso_q[i]);
        end
        chk_eq("rsp_data", 64'(rsp_data), exp_rx);
        chk_eq("cs_n_end", 64'(cs_n), 64'(!hold));
        @(negedge clk);
        chk_eq("rsp_pulse", 64'(rsp_valid), 64'd0);
        chk_eq("rsp_hold", 64'(rsp_data), exp_rx);
    endtask

    initial begin
        int            snap_cs, snap_rises, base_rsp, base_acc, t0;
        bit            seen;
        int            b_nb[4];
        logic [DW-1:0] b_d[4];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_ready", 64'(req_ready), 64'd1);
        chk_eq("rst_sclk", 64'(sclk), 64'd0);
        chk_eq("rst_mosi", 64'(mosi), 64'd0);
        chk_eq("rst_cs_n", 64'(cs_n), 64'd1);
        chk_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk_eq("rst_rsp_data", 64'(rsp_data), 64'd0);

        run_frame(40, 48'hccdf1745ad08, 1'b0, 0);

        // Held chip select across two frames.
        #1 snap_rises = total_rises;
        run_frame(40, {$urandom, $urandom}, 1'b1, 1);
        #1 snap_cs = cs_high_cnt;
        run_frame(16, 48'h00000000dead, 1'b0, 0);
        #1;
        chk_eq("hold_cs_continuous", 64'(cs_high_cnt), 64'(snap_cs + 2));
        chk_eq("hold_total_rises", 64'(total_rises - snap_rises), 64'd56);

        run_frame(0, {$urandom, $urandom}, 1'b0, 2);

        for (int i = 0; i < 8; i++)
            run_frame(int'($urandom_range(0, 63)), {$urandom, $urandom},
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

        // Reset in the middle of a 40-bit frame.
        @(posedge clk); #1;
        miso_mode = 1; rises = 0; mosi_q.delete(); miso_q.delete();
        req_valid = 1'b1; req_nbits = 6'd40; req_data = {$urandom, $urandom}; req_hold_cs = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin @(negedge clk); seen = req_ready; end
        chk_eq("abort_accept", 64'(seen), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin @(negedge clk); #1 seen = (rises >= 10); end
        chk_eq("abort_rise10", 64'(seen), 64'd1);
        base_rsp = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("abort_cs_n", 64'(cs_n), 64'd1);
        chk_eq("abort_sclk", 64'(sclk), 64'd0);
        chk_eq("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (400) @(negedge clk);
        #1;
        chk_eq("abort_no_rsp", 64'(rsp_cnt - base_rsp), 64'd0);
        chk_eq("abort_ready", 64'(req_ready), 64'd1);

        // Back-to-back requests with req_valid held high throughout.
        for (int i = 0; i < 4; i++) begin
            b_nb[i] = int'($urandom_range(1, 20));
            b_d[i]  = {$urandom, $urandom};
        end
        min_gap = 1000000; base_rsp = rsp_cnt; base_acc = acc_cnt;
        @(posedge clk); #1;
        miso_mode = 0;
        req_valid = 1'b1; req_nbits = b_nb[0][5:0]; req_data = b_d[0]; req_hold_cs = 1'b0;
        for (int r = 0; r < 4; r++) begin
            seen = 1'b0;
            for (int k = 0; k < 2000 && !seen; k++) begin @(negedge clk); seen = req_ready; end
            chk_eq("b2b_accept", 64'(seen), 64'd1);
            @(posedge clk); #1;
            if (r < 3) begin req_nbits = b_nb[r+1][5:0]; req_data = b_d[r+1]; end
            else req_valid = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 1000 && !seen; k++) begin @(negedge clk); seen = rsp_valid; end
            chk_eq("b2b_rsp_seen", 64'(seen), 64'd1);
            chk_eq("b2b_rsp_data", 64'(rsp_data), 64'(b_d[r]) & ((64'd1 << b_nb[r]) - 64'd1));
        end
        repeat (20) @(negedge clk);
        #1;
        chk_eq("b2b_accepts", 64'(acc_cnt - base_acc), 64'd4);
        chk_eq("b2b_rsps", 64'(rsp_cnt - base_rsp), 64'd4);
        chk_eq("b2b_min_cs_gap", 64'(min_gap >= int'(DIV)), 64'd1);

        // Shortest frame on the CLK_DIV=2 instance.
        @(posedge clk); #1;
        rises2 = 0; req_valid2 = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = req_ready2; end
        chk_eq("div2_accept", 64'(seen), 64'd1);
        t0 = cyc;
        @(posedge clk); #1 req_valid2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin @(negedge clk); seen = rsp_valid2; end
        chk_eq("div2_rsp_seen", 64'(seen), 64'd1);
        chk_eq("div2_duration", 64'(cyc - t0), 64'd7);
        chk_eq("div2_rises", 64'(rises2), 64'd1);
        chk_eq("div2_rsp_data", 64'(rsp_data2), 64'd0);

        chk_eq("mosi_timing", 64'(mosi_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
